ram_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port data RAM between `NUM_PORTS` requesters using the req/gnt/rvalid handshake of the core memory ports. It replaces fixed-priority muxing wherever more than two masters (core data, debug, DMA, AXI bridge) hit the same RAM and starvation is unacceptable. It tracks in-flight accesses through a latency pipeline so each read response is routed back to the port that issued it, for any fixed RAM read latency.

---
 rtl/ram_rr_arbiter_if.sv | 21 ++
 rtl/ram_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_ram_rr_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_rr_arbiter_if.sv
// Requester-side bus of ram_rr_arbiter: NUM_PORTS req/gnt/rvalid memory ports
// sharing one read-data bus.
interface ram_rr_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]                   req_i;
  logic [NUM_PORTS-1:0]                   gnt_o;
  logic [NUM_PORTS-1:0]                   rvalid_o;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i;
  logic [NUM_PORTS-1:0]                   we_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i;
  logic [DATA_WIDTH-1:0]                  rdata_o;

  modport master (output req_i, addr_i, we_i, be_i, wdata_i,
                  input  gnt_o, rvalid_o, rdata_o);
  modport slave  (input  req_i, addr_i, we_i, be_i, wdata_i,
                  output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_PORTS requesters,
// routing responses back by port id. Optional grant locking: RAM_RR_ARB_LOCK_EN.

// Per-port grant / response decode.
module ram_rr_arbiter_lane #(
  parameter int PW   = 2,
  parameter int LANE = 0
) (
  input  logic          any,
  input  logic [PW-1:0] win,
  input  logic          rsp_vld,
  input  logic [PW-1:0] rsp_id,
  output logic          gnt,
  output logic          rvalid
);
  assign gnt    = any && (win == PW'(LANE));
  assign rvalid = rsp_vld && (rsp_id == PW'(LANE));
endmodule

module ram_rr_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ram_rr_arbiter_if.slave         bus,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
`ifdef RAM_RR_ARB_LOCK_EN
  ,
  input  logic [NUM_PORTS-1:0]    lock_i
`endif
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [PW:0]   NP   = (PW+1)'(NUM_PORTS);
  localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BW-1:0]         be;
    logic [DATA_WIDTH-1:0] wdata;
  } ram_cmd_t;

  logic [NUM_PORTS-1:0]           elig, gnt, rvalid;
  logic [PW-1:0]                  ptr_q, ptr_d, win;
  logic [PW:0]                    idx;
  logic                           any, hold;
  ram_cmd_t [NUM_PORTS-1:0]       cmd_arr;
  ram_cmd_t                       cmd;
  logic [RAM_LATENCY-1:0]         vld_pipe;
  logic [RAM_LATENCY-1:0][PW-1:0] id_pipe;

  // Search from ptr upward, wrapping; first eligible requester wins.
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(i);
      if (idx >= NP) idx = idx - NP;
      if (!any && elig[idx[PW-1:0]]) begin
        any = 1'b1;
        win = idx[PW-1:0];
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
    assign cmd_arr[g] = '{addr: bus.addr_i[g], we: bus.we_i[g],
                          be: bus.be_i[g], wdata: bus.wdata_i[g]};
    ram_rr_arbiter_lane #(.PW(PW), .LANE(g)) u_lane (
      .any    (any),
      .win    (win),
      .rsp_vld(vld_pipe[RAM_LATENCY-1]),
      .rsp_id (id_pipe[RAM_LATENCY-1]),
      .gnt    (gnt[g]),
      .rvalid (rvalid[g])
    );
  end

  assign cmd          = any ? cmd_arr[win] : '0;
  assign ram_en_o     = any;
  assign ram_addr_o   = cmd.addr;
  assign ram_we_o     = cmd.we;
  assign ram_be_o     = cmd.be;
  assign ram_wdata_o  = cmd.wdata;
  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid;
  assign bus.rdata_o  = ram_rdata_i;

  always_comb begin
    ptr_d = ptr_q;
    if (any && !hold) ptr_d = (win == LAST) ? '0 : win + 1'b1;
  end

  // Every granted access, read or write, travels the pipe and yields one rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      vld_pipe[0] <= any;
      id_pipe[0]  <= win;
      for (int s = 1; s < RAM_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
    end
  end

`ifdef RAM_RR_ARB_LOCK_EN
  logic          locked_q, locked_d;
  logic [PW-1:0] owner_q, owner_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= 1'b0;
      owner_q  <= '0;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    locked_d = locked_q;
    owner_d  = owner_q;
    if (locked_q) begin
      if (!lock_i[owner_q] && (gnt[owner_q] || !bus.req_i[owner_q])) locked_d = 1'b0;
    end else if (any && lock_i[win]) begin
      locked_d = 1'b1;
      owner_d  = win;
    end
  end

  // While locked only the owner is eligible and the pointer is frozen.
  always_comb begin
    elig = bus.req_i;
    hold = locked_q;
    if (locked_q) elig = bus.req_i & (NUM_PORTS'(1) << owner_q);
  end
`else
  always_comb begin
    elig = bus.req_i;
    hold = 1'b0;
  end
`endif

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Randomized self-checking bench for ram_rr_arbiter against a cycle-level
// reference model of arbitration, lock rules and RAM contents.
module tb_ram_rr_arbiter;
  localparam int N = 4, AW = 32, DW = 32, LAT = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_rr_arbiter_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [3:0]    ram_be_o;
  logic [DW-1:0] ram_wdata_o, ram_rdata_i;
  logic [N-1:0]  lk;

  ram_rr_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ram_en_o   (ram_en_o),
    .ram_addr_o (ram_addr_o),
    .ram_we_o   (ram_we_o),
    .ram_be_o   (ram_be_o),
    .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i)
`ifdef RAM_RR_ARB_LOCK_EN
    ,
    .lock_i     (lk)
`endif
  );

  int checks = 0, errors = 0, cyc = 0;
  int m_ptr = 0, m_owner = 0;
  bit m_locked = 1'b0;
  logic [N-1:0]  exp_rv [16];
  bit            exp_isrd [16];
  logic [DW-1:0] exp_rd [16];
  logic [DW-1:0] env_rd [16];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] env_mem [logic [AW-1:0]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic set_port(input int p, input logic w, input logic [3:0] be,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we_i[p]    = w;
    bus.be_i[p]    = be;
    bus.addr_i[p]  = a;
    bus.wdata_i[p] = d;
  endtask

  // One clock: entered at posedge+1 with inputs applied, checks at negedge.
  task automatic tick();
    int win, slot, nslot;
    logic [AW-1:0] a;
    slot = cyc % 16;
    ram_rdata_i = env_rd[slot];
    @(negedge clk);
    win = -1;
    if (m_locked) begin
      if (bus.req_i[m_owner]) win = m_owner;
    end else begin
      for (int i = 0; i < N; i++)
        if (win < 0 && bus.req_i[(m_ptr + i) % N]) win = (m_ptr + i) % N;
    end
    chk("gnt", 64'(bus.gnt_o), (win >= 0) ? (64'd1 << win) : 64'd0);
    chk("ram_en", 64'(ram_en_o), 64'(win >= 0));
    if (win >= 0) begin
      chk("ram_addr", 64'(ram_addr_o), 64'(bus.addr_i[win]));
      chk("ram_we", 64'(ram_we_o), 64'(bus.we_i[win]));
      chk("ram_be", 64'(ram_be_o), 64'(bus.be_i[win]));
      chk("ram_wdata", 64'(ram_wdata_o), 64'(bus.wdata_i[win]));
    end else begin
      chk("idle_addr", 64'(ram_addr_o), 64'd0);
      chk("idle_cmd", 64'({ram_we_o, ram_be_o, ram_wdata_o}), 64'd0);
    end
    chk("rvalid", 64'(bus.rvalid_o), 64'(exp_rv[slot]));
    if (exp_rv[slot] != '0 && exp_isrd[slot]) chk("rdata", 64'(bus.rdata_o), 64'(exp_rd[slot]));
    exp_rv[slot] = '0;

    if (win >= 0) begin
      nslot = (cyc + LAT) % 16;
      a = bus.addr_i[win];
      exp_rv[nslot]   = 4'b0001 << win;
      exp_isrd[nslot] = !bus.we_i[win];
      exp_rd[nslot]   = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
      if (bus.we_i[win]) ref_mem[a] = merge(exp_rd[nslot], bus.wdata_i[win], bus.be_i[win]);
    end
    if (m_locked) begin
      if (!lk[m_owner] && (win == m_owner || !bus.req_i[m_owner])) m_locked = 1'b0;
    end else if (win >= 0) begin
      m_ptr = (win + 1) % N;
      if (lk[win]) begin
        m_locked = 1'b1;
        m_owner  = win;
      end
    end

    // RAM behaviour: read-before-write, data returned LAT cycles later.
    if (ram_en_o) begin
      nslot = (cyc + LAT) % 16;
      a = ram_addr_o;
      env_rd[nslot] = env_mem.exists(a) ? env_mem[a] : dflt(a);
      if (ram_we_o) env_mem[a] = merge(env_rd[nslot], ram_wdata_o, ram_be_o);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_i = '0;
    lk = '0;
    #1;
    chk("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
    chk("rst_gnt", 64'(bus.gnt_o), 64'd0);
    chk("rst_ram", 64'({ram_en_o, ram_addr_o, ram_we_o}), 64'd0);
    for (int i = 0; i < 16; i++) exp_rv[i] = '0;
    m_ptr = 0;
    m_locked = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  initial begin
    bus.req_i = '0;
    lk = '0;
    ram_rdata_i = '0;
    for (int i = 0; i < 16; i++) begin
      env_rd[i] = '0;
      exp_rd[i] = '0;
      exp_isrd[i] = 1'b0;
    end
    for (int p = 0; p < N; p++) set_port(p, 1'b0, 4'hF, AW'(p * 4), '0);
    @(posedge clk);
    #1;
    do_reset();

    // All requesting: rotation 0,1,2,3,0,... with rvalid trailing by LAT.
    bus.req_i = 4'b1111;
    repeat (8) tick();
    bus.req_i = '0;
    repeat (LAT) tick();

    // Move ptr to 2, then lower-numbered requesters win by wrap-around.
    bus.req_i = 4'b0010; tick();
    bus.req_i = 4'b0011; tick();
    bus.req_i = 4'b0010; tick();
    bus.req_i = '0;
    repeat (LAT) tick();

    // Known-data read from port 1.
    env_mem[32'h40] = 32'hDEADBEEF;
    ref_mem[32'h40] = 32'hDEADBEEF;
    set_port(1, 1'b0, 4'hF, 32'h40, '0);
    bus.req_i = 4'b0010; tick();
    bus.req_i = '0;
    repeat (LAT) tick();

    // Reset with two reads in flight: nothing delivered, port 0 next.
    bus.req_i = 4'b0011; tick(); tick();
    do_reset();
    repeat (LAT + 1) tick();
    bus.req_i = 4'b1111; tick();
    bus.req_i = '0;
    repeat (LAT) tick();

    // Partial write from port 3, then read it back.
    set_port(3, 1'b1, 4'b0011, 32'h10, 32'h12345678);
    bus.req_i = 4'b1000; tick();
    set_port(3, 1'b0, 4'hF, 32'h10, '0);
    tick();
    bus.req_i = '0;
    repeat (LAT) tick();

`ifdef RAM_RR_ARB_LOCK_EN
    bus.req_i = 4'b0100; lk = 4'b0100; tick();
    bus.req_i = 4'b1111;
    repeat (3) tick();
    lk = '0; tick();
    tick();
    bus.req_i = '0;
    repeat (LAT) tick();
`endif

    repeat (400) begin
      bus.req_i = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
      for (int p = 0; p < N; p++)
        set_port(p, 1'($urandom), 4'($urandom), {26'd0, 4'($urandom), 2'b00}, $urandom);
`ifdef RAM_RR_ARB_LOCK_EN
      lk = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
`endif
      if ($urandom_range(0, 99) == 0) do_reset();
      else tick();
    end
    bus.req_i = '0;
    lk = '0;
    repeat (LAT + 1) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
